fm_ftw_gen: RTL and testbench



---
 rtl/fm_ftw_gen.sv | 194 +++++++++++++++++++
 tb/tb_fm_ftw_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fm_ftw_gen.sv
// fm_ftw_gen -- FM tuning-word generator for a DDS.
//
// Takes the stereo sample pair and new-sample strobe from an I2S receiver,
// brings the strobe into the DDS clock domain, mixes the pair to mono and
// ramps linearly from the previous sample to the new one over
// 2^INTERP_LOG2 cycles. The ramped value, scaled by 2^DEV_SHIFT, is added
// to the carrier tuning word. If no sample arrives for TIMEOUT cycles the
// output ramps back to the bare carrier and 'muted' is raised.
//
// Ports:
//   clk            DDS system clock
//   rst            asynchronous active-high reset
//   first_channel  signed left sample (I2S domain, stable between strobes)
//   second_channel signed right sample (I2S domain)
//   data_updated   new-sample pulse from the I2S domain
//   ftw            registered frequency tuning word
//   sample_strobe  one-cycle pulse when a sample is accepted
//   muted          high while no valid audio is present
module fm_ftw_gen #(
  parameter int                   CH_WIDTH    = 16,
  parameter int                   FTW_WIDTH   = 32,
  parameter logic [FTW_WIDTH-1:0] CARRIER_FTW = 32'h1000_0000,
  parameter int                   DEV_SHIFT   = 4,
  parameter int                   INTERP_LOG2 = 6,
  parameter int                   TIMEOUT     = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_WIDTH-1:0]  first_channel,
  input  logic [CH_WIDTH-1:0]  second_channel,
  input  logic                 data_updated,
  output logic [FTW_WIDTH-1:0] ftw,
  output logic                 sample_strobe,
  output logic                 muted
);

  localparam int IW = CH_WIDTH + 1;        // integer part of the accumulator
  localparam int AW = IW + INTERP_LOG2;    // accumulator incl. fraction bits
  localparam int SW = CH_WIDTH + 2;        // step: difference of two IW values
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0]          TIMEOUT_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0]          TIMEOUT_FIRE = TW'(TIMEOUT - 1);
  localparam logic [INTERP_LOG2-1:0] CNT_LAST     = '1;

  generate
    if (CH_WIDTH + DEV_SHIFT >= FTW_WIDTH) begin : g_width_check
      $error("fm_ftw_gen: CH_WIDTH+DEV_SHIFT must be less than FTW_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_t;

  // ---------------------------------------------------------------------
  // Strobe synchroniser: sync_reg[0]=s1, [1]=s2, [2]=s3.
  // live_reg marks when s2 carries a genuinely sampled value after reset;
  // armed_reg then requires s2 to have been seen low once, so a strobe
  // that is already high when reset is released is not mistaken for a
  // fresh rising edge.
  // ---------------------------------------------------------------------
  logic [2:0] sync_reg;
  logic [1:0] live_reg;
  logic       armed_reg;
  logic       accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= '0;
      live_reg  <= '0;
      armed_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], data_updated};
      live_reg <= {live_reg[0], 1'b1};
      if (live_reg[1] && !sync_reg[1]) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign accept = sync_reg[1] & ~sync_reg[2] & armed_reg;

  // Mono mix: sum at CH_WIDTH+1 bits, arithmetic halve, truncate.
  logic signed [IW-1:0]       sum_w;
  logic signed [CH_WIDTH-1:0] mono_w;

  assign sum_w  = $signed({first_channel[CH_WIDTH-1], first_channel})
                + $signed({second_channel[CH_WIDTH-1], second_channel});
  assign mono_w = CH_WIDTH'(sum_w >>> 1);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t                      state_reg, state_next;
  logic signed [AW-1:0]        acc_reg, acc_next;
  logic signed [CH_WIDTH-1:0]  target_reg, target_next;
  logic signed [SW-1:0]        step_reg, step_next;
  logic [INTERP_LOG2-1:0]      cnt_reg, cnt_next;
  logic [TW-1:0]               tcnt_reg, tcnt_next;
  logic                        muted_reg, muted_next;
  logic                        strobe_reg, strobe_next;
  logic [FTW_WIDTH-1:0]        ftw_reg, ftw_next;

  logic signed [IW-1:0]        acc_int_w;
  logic signed [FTW_WIDTH-1:0] dev_w;

  // Integer part of the accumulator (equivalent to acc >>> INTERP_LOG2).
  assign acc_int_w = acc_reg[AW-1:INTERP_LOG2];
  assign dev_w     = FTW_WIDTH'(acc_int_w) <<< DEV_SHIFT;
  assign ftw_next  = CARRIER_FTW + $unsigned(dev_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      target_reg <= '0;
      step_reg   <= '0;
      cnt_reg    <= '0;
      tcnt_reg   <= '0;
      muted_reg  <= 1'b1;
      strobe_reg <= 1'b0;
      ftw_reg    <= CARRIER_FTW;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      target_reg <= target_next;
      step_reg   <= step_next;
      cnt_reg    <= cnt_next;
      tcnt_reg   <= tcnt_next;
      muted_reg  <= muted_next;
      strobe_reg <= strobe_next;
      ftw_reg    <= ftw_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    target_next = target_reg;
    step_next   = step_reg;
    cnt_next    = cnt_reg;
    tcnt_next   = tcnt_reg;
    muted_next  = muted_reg;
    strobe_next = 1'b0;

    // Silence counter saturates, so the mute ramp is launched only once.
    if (tcnt_reg != TIMEOUT_MAX) begin
      tcnt_next = tcnt_reg + 1'b1;
    end

    case (state_reg)
      LOAD: begin
        // Step is the integer distance, applied in fractional units, so
        // 2^INTERP_LOG2 additions cover the whole distance.
        step_next  = SW'(target_reg) - SW'(acc_int_w);
        cnt_next   = '0;
        state_next = RAMP;
      end
      RAMP: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          // Snap to the exact target so truncation error never accumulates.
          acc_next   = AW'(target_reg) <<< INTERP_LOG2;
          state_next = HOLD;
        end else begin
          acc_next = acc_reg + AW'(step_reg);
        end
      end
      default: ;  // IDLE and HOLD keep the accumulator
    endcase

    if (tcnt_reg == TIMEOUT_FIRE) begin
      muted_next  = 1'b1;
      target_next = '0;
      state_next  = LOAD;
    end

    // A new sample overrides everything, including a simultaneous timeout.
    // The accumulator is held so the restarted ramp begins where the old
    // one stopped.
    if (accept) begin
      strobe_next = 1'b1;
      target_next = mono_w;
      tcnt_next   = '0;
      muted_next  = 1'b0;
      acc_next    = acc_reg;
      state_next  = LOAD;
    end
  end

  assign ftw           = ftw_reg;
  assign sample_strobe = strobe_reg;
  assign muted         = muted_reg;

endmodule

// File: tb/tb_fm_ftw_gen.sv
// Testbench for fm_ftw_gen: directed samples, expected responses queued at
// issue time and checked by an independent monitor on each sample_strobe.
module tb_fm_ftw_gen;

  localparam logic [31:0] CARRIER = 32'h1000_0000;
  localparam int          SETTLE  = 66;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] first_channel;
  logic [15:0] second_channel;
  logic        data_updated;
  logic [31:0] ftw;
  logic        sample_strobe;
  logic        muted;

  always #5 clk = ~clk;

  fm_ftw_gen #(.TIMEOUT(200)) dut (
    .clk           (clk),
    .rst           (rst),
    .first_channel (first_channel),
    .second_channel(second_channel),
    .data_updated  (data_updated),
    .ftw           (ftw),
    .sample_strobe (sample_strobe),
    .muted         (muted)
  );

  typedef struct {
    int          exp_cycle;
    logic [31:0] final_ftw;
    bit          settle;
    int          dir;
    bit          has_pre;
    logic [31:0] pre_ftw;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] max_delta;
  logic [31:0] prev_any;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per strobe and follows the ramp that
  // the strobe starts.
  initial begin
    exp_t        e;
    bit          win;
    int          due;
    int          wdir;
    bit          wsettle;
    bit          whas_pre;
    logic [31:0] wfinal;
    logic [31:0] wpre;
    logic [31:0] prev;
    logic [31:0] d;
    logic        mono_bad;
    string       wname;
    win       = 0;
    prev_any  = CARRIER;
    max_delta = '0;
    forever begin
      @(negedge clk);
      d = (ftw > prev_any) ? ftw - prev_any : prev_any - ftw;
      if (d > max_delta) max_delta = d;
      prev_any = ftw;
      if (win) begin
        if (wdir > 0 && ftw < prev) mono_bad = 1'b1;
        if (wdir < 0 && ftw > prev) mono_bad = 1'b1;
        prev = ftw;
        if (whas_pre && cyc == due - 1) check({wname, "_pre_final"}, ftw, wpre);
        if (cyc == due) begin
          if (wsettle) check({wname, "_final_ftw"}, ftw, wfinal);
          if (wdir != 0) check({wname, "_monotonic"}, {31'b0, mono_bad}, 32'd0);
          win = 0;
        end
      end
      if (sample_strobe) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: strobe at cycle %0d, required none", cyc);
        end else begin
          e = sb_q.pop_front();
          $display("txn %s: strobe at cycle %0d (expected %0d) muted=%0b ftw=%h",
                   e.name, cyc, e.exp_cycle, muted, ftw);
          check({e.name, "_strobe_cycle"}, 32'(cyc), 32'(e.exp_cycle));
          check({e.name, "_muted_low"}, {31'b0, muted}, 32'd0);
          win      = 1;
          due      = cyc + SETTLE;
          wdir     = e.dir;
          wsettle  = e.settle;
          whas_pre = e.has_pre;
          wfinal   = e.final_ftw;
          wpre     = e.pre_ftw;
          wname    = e.name;
          prev     = ftw;
          mono_bad = 1'b0;
        end
      end
    end
  end

  // Issue one data_updated pulse and queue the expected response.
  task automatic send(input logic [15:0] l, input logic [15:0] r, input string name,
                      input logic [31:0] fin, input bit settle, input int dir,
                      input bit has_pre, input logic [31:0] pre, output int strobe_cyc);
    exp_t e;
    @(posedge clk);
    #1;
    first_channel  = l;
    second_channel = r;
    data_updated   = 1'b1;
    e.exp_cycle = cyc + 3;
    e.final_ftw = fin;
    e.settle    = settle;
    e.dir       = dir;
    e.has_pre   = has_pre;
    e.pre_ftw   = pre;
    e.name      = name;
    sb_q.push_back(e);
    strobe_cyc = cyc + 3;
    repeat (4) @(posedge clk);
    #1 data_updated = 1'b0;
  endtask

  task automatic wait_until(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  initial begin
    int s;
    int s2;
    rst            = 1'b1;
    data_updated   = 1'b0;
    first_channel  = '0;
    second_channel = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset_ftw", ftw, CARRIER);
    check("reset_muted", {31'b0, muted}, 32'd1);
    check("reset_strobe", {31'b0, sample_strobe}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("idle_ftw", ftw, CARRIER);
    check("idle_muted", {31'b0, muted}, 32'd1);

    // Single sample: (1000+3000)/2 = 2000 -> 2000<<4 = 0x7D00
    send(16'd1000, 16'd3000, "single", 32'h1000_7D00, 1, 1, 1, 32'h1000_7B00, s);
    wait_until(s + 80);

    // Extremes
    send(16'h8000, 16'h8000, "neg_full", 32'h0FF8_0000, 1, -1, 0, '0, s);
    wait_until(s + 80);
    send(16'h7FFF, 16'h8000, "minus_one", 32'h0FFF_FFF0, 1, 1, 0, '0, s);
    wait_until(s + 80);

    // Mid-ramp retarget: 2000, then 0 about 20 cycles into the ramp
    #1 max_delta = '0;
    send(16'd2000, 16'd2000, "retgt_a", '0, 0, 1, 0, '0, s);
    wait_until(s + 19);
    send(16'd0, 16'd0, "retgt_b", CARRIER, 1, -1, 0, '0, s2);
    wait_until(s2 + 80);
    checks++;
    if (max_delta > 32'h200) begin
      errors++;
      $display("FAIL retgt_max_jump: got %0d, required <= 512", max_delta);
    end

    // Timeout (TIMEOUT=200)
    send(16'd2000, 16'd2000, "to_sample", 32'h1000_7D00, 1, 1, 1, 32'h1000_7B00, s);
    wait_until(s + 199);
    check("to_muted_before", {31'b0, muted}, 32'd0);
    wait_until(s + 200);
    check("to_muted_rise", {31'b0, muted}, 32'd1);
    wait_until(s + 265);
    check("to_ramp_pre", ftw, 32'h1000_01F0);
    wait_until(s + 266);
    check("to_carrier", ftw, CARRIER);
    wait_until(s + 300);
    check("to_still_muted", {31'b0, muted}, 32'd1);
    check("to_still_carrier", ftw, CARRIER);
    send(16'hFC18, 16'hFC18, "unmute", 32'h0FFF_C180, 1, -1, 0, '0, s);
    wait_until(s + 80);

    // Asynchronous reset in the middle of a ramp, strobe stuck high
    send(16'd2000, 16'd2000, "rst_ramp", '0, 0, 0, 0, '0, s);
    wait_until(s + 30);
    #2;
    rst          = 1'b1;
    data_updated = 1'b1;
    #1;
    check("rst_async_ftw", ftw, CARRIER);
    check("rst_async_muted", {31'b0, muted}, 32'd1);
    check("rst_async_strobe", {31'b0, sample_strobe}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_stuck_ftw", ftw, CARRIER);
    check("rst_stuck_muted", {31'b0, muted}, 32'd1);
    data_updated = 1'b0;
    repeat (5) @(posedge clk);
    send(16'd1000, 16'd1000, "rearm", 32'h1000_3E80, 1, 1, 0, '0, s);
    wait_until(s + 80);

    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
